lock_ctrl: RTL and testbench

LOCK_CTRL -- requirements
Module: lock_ctrl

---
 rtl/lock_pkg.sv | 29 ++
 rtl/lock_timer.sv | 40 ++++
 rtl/lock_ctrl.sv | 152 +++++++++++++++
 tb/tb_lock_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lock_pkg
//  Description : Shared types and defaults for the keypad lock controller.
//                Holds the controller state enum, the default timing and
//                attempt-limit constants, and a small width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package lock_pkg;

    // Controller states: closed and accepting code bits, open, or blocked.
    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        UNLOCKED = 2'd1,
        LOCKOUT  = 2'd2
    } lock_state_t;

    localparam int c_UNLOCK_CYC  = 8;
    localparam int c_WINDOW      = 16;
    localparam int c_MAX_FAIL    = 3;
    localparam int c_LOCKOUT_CYC = 32;

    // Bits needed to hold values 0..max_val-1, never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lock_timer.sv
`default_nettype none
// ============================================================================
//  Module      : lock_timer
//  Description : Loadable down-counter. A load writes load_val; otherwise the
//                count decrements once per cycle and rests at zero.
//  Ports       : clk      - system clock
//                rst      - synchronous active-high reset (count -> 0)
//                load     - load load_val this cycle (wins over decrement)
//                load_val - value to load
//                zero     - high while the count is zero
//  Revision    : 1.0  initial release
// ============================================================================
module lock_timer
    import lock_pkg::*;
#(
    parameter int WIDTH = cnt_width(c_LOCKOUT_CYC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/lock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lock_ctrl
//  Description : Keypad lock controller. Counts code bits per attempt window,
//                opens for UNLOCK_CYC cycles on a correct code, and blocks
//                input for LOCKOUT_CYC cycles after MAX_FAIL consecutive
//                failed attempts.
//  Ports       : clk       - system clock
//                rst       - synchronous active-high reset
//                bit_valid - strobe, one keypad code bit presented
//                match     - pulse, correct code detected upstream
//                relock    - level, close the lock early
//                unlocked  - high while open
//                lockout   - high while input is blocked
//                alarm     - one-cycle pulse on entry to lockout
//                fail_cnt  - consecutive failed attempts (saturating)
//  Revision    : 1.0  initial release
// ============================================================================
module lock_ctrl
    import lock_pkg::*;
#(
    parameter int UNLOCK_CYC  = c_UNLOCK_CYC,
    parameter int WINDOW      = c_WINDOW,
    parameter int MAX_FAIL    = c_MAX_FAIL,
    parameter int LOCKOUT_CYC = c_LOCKOUT_CYC
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          bit_valid,
    input  logic                          match,
    input  logic                          relock,
    output logic                          unlocked,
    output logic                          lockout,
    output logic                          alarm,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);

    localparam int c_TIMER_W = cnt_width((UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC);
    localparam int c_BIT_W   = cnt_width(WINDOW);
    localparam int c_FAIL_W  = $clog2(MAX_FAIL + 1);

    localparam logic [c_BIT_W-1:0]   c_BIT_LAST   = c_BIT_W'(WINDOW - 1);
    localparam logic [c_FAIL_W-1:0]  c_FAIL_LAST  = c_FAIL_W'(MAX_FAIL - 1);
    localparam logic [c_FAIL_W-1:0]  c_FAIL_MAX   = c_FAIL_W'(MAX_FAIL);
    localparam logic [c_TIMER_W-1:0] c_OPEN_LOAD  = c_TIMER_W'(UNLOCK_CYC - 1);
    localparam logic [c_TIMER_W-1:0] c_BLOCK_LOAD = c_TIMER_W'(LOCKOUT_CYC - 1);

    lock_state_t          r_state,    w_state_nx;
    logic [c_BIT_W-1:0]   r_bit_cnt,  w_bit_cnt_nx;
    logic [c_FAIL_W-1:0]  r_fail_cnt, w_fail_cnt_nx;
    logic                 r_alarm,    w_alarm_nx;
    logic                 w_load;
    logic [c_TIMER_W-1:0] w_load_val;
    logic                 w_zero;

    lock_timer #(
        .WIDTH    (c_TIMER_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .zero     (w_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= LOCKED;
            r_bit_cnt  <= '0;
            r_fail_cnt <= '0;
            r_alarm    <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_bit_cnt  <= w_bit_cnt_nx;
            r_fail_cnt <= w_fail_cnt_nx;
            r_alarm    <= w_alarm_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_bit_cnt_nx  = r_bit_cnt;
        w_fail_cnt_nx = r_fail_cnt;
        w_alarm_nx    = 1'b0;
        w_load        = 1'b0;
        w_load_val    = '0;

        case (r_state)
            LOCKED: begin
                // A match beats a window-end failure in the same cycle.
                if (match) begin
                    w_state_nx    = UNLOCKED;
                    w_bit_cnt_nx  = '0;
                    w_fail_cnt_nx = '0;
                    w_load        = 1'b1;
                    w_load_val    = c_OPEN_LOAD;
                end else if (bit_valid) begin
                    if (r_bit_cnt == c_BIT_LAST) begin
                        w_bit_cnt_nx = '0;
                        if (r_fail_cnt != c_FAIL_MAX) begin
                            w_fail_cnt_nx = r_fail_cnt + 1'b1;
                        end
                        if (r_fail_cnt == c_FAIL_LAST) begin
                            w_state_nx = LOCKOUT;
                            w_alarm_nx = 1'b1;
                            w_load     = 1'b1;
                            w_load_val = c_BLOCK_LOAD;
                        end
                    end else begin
                        w_bit_cnt_nx = r_bit_cnt + 1'b1;
                    end
                end
            end

            UNLOCKED: begin
                // relock > match (extend) > expiry; a match on the final
                // open cycle still extends the open time.
                if (relock) begin
                    w_state_nx   = LOCKED;
                    w_bit_cnt_nx = '0;
                end else if (match) begin
                    w_load     = 1'b1;
                    w_load_val = c_OPEN_LOAD;
                end else if (w_zero) begin
                    w_state_nx   = LOCKED;
                    w_bit_cnt_nx = '0;
                end
            end

            LOCKOUT: begin
                if (w_zero) begin
                    w_state_nx    = LOCKED;
                    w_bit_cnt_nx  = '0;
                    w_fail_cnt_nx = '0;
                end
            end

            default: begin
                w_state_nx    = LOCKED;
                w_bit_cnt_nx  = '0;
                w_fail_cnt_nx = '0;
            end
        endcase
    end

    assign unlocked = (r_state == UNLOCKED);
    assign lockout  = (r_state == LOCKOUT);
    assign alarm    = r_alarm;
    assign fail_cnt = r_fail_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lock_ctrl
//  Description : Self-checking bench for lock_ctrl: directed scenarios plus
//                randomized traffic compared against a cycle-count model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lock_ctrl;

    localparam int UNLOCK_CYC  = 8;
    localparam int WINDOW      = 16;
    localparam int MAX_FAIL    = 3;
    localparam int LOCKOUT_CYC = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       bit_valid = 1'b0;
    logic       match = 1'b0;
    logic       relock = 1'b0;
    logic       unlocked;
    logic       lockout;
    logic       alarm;
    logic [1:0] fail_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: remaining open cycles, remaining blocked cycles, bits in the
    // current attempt, consecutive failures, alarm for the current cycle.
    int   m_open  = 0;
    int   m_block = 0;
    int   m_bits  = 0;
    int   m_fails = 0;
    logic m_alarm = 1'b0;

    lock_ctrl #(
        .UNLOCK_CYC  (UNLOCK_CYC),
        .WINDOW      (WINDOW),
        .MAX_FAIL    (MAX_FAIL),
        .LOCKOUT_CYC (LOCKOUT_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bit_valid (bit_valid),
        .match     (match),
        .relock    (relock),
        .unlocked  (unlocked),
        .lockout   (lockout),
        .alarm     (alarm),
        .fail_cnt  (fail_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic void model_step(input logic bv, input logic m, input logic rl, input logic r);
        m_alarm = 1'b0;
        if (r) begin
            m_open = 0; m_block = 0; m_bits = 0; m_fails = 0;
        end else if (m_open > 0) begin
            if (rl) begin
                m_open = 0; m_bits = 0;
            end else if (m) begin
                m_open = UNLOCK_CYC;
            end else begin
                m_open--;
                if (m_open == 0) m_bits = 0;
            end
        end else if (m_block > 0) begin
            m_block--;
            if (m_block == 0) begin
                m_fails = 0; m_bits = 0;
            end
        end else if (m) begin
            m_open = UNLOCK_CYC; m_bits = 0; m_fails = 0;
        end else if (bv) begin
            m_bits++;
            if (m_bits == WINDOW) begin
                m_bits = 0;
                if (m_fails < MAX_FAIL) m_fails++;
                if (m_fails == MAX_FAIL) begin
                    m_block = LOCKOUT_CYC;
                    m_alarm = 1'b1;
                end
            end
        end
    endfunction

    // One clock cycle: inputs applied just after an edge, sampled 1ns after
    // the next edge.
    task automatic tick(input logic bv, input logic m, input logic rl, input logic r);
        bit_valid = bv; match = m; relock = rl; rst = r;
        @(posedge clk); #1;
        bit_valid = 1'b0; match = 1'b0; relock = 1'b0; rst = 1'b0;
        model_step(bv, m, rl, r);
    endtask

    task automatic test_reset;
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if ({unlocked, lockout, alarm, fail_cnt} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b exp=00000", {unlocked, lockout, alarm, fail_cnt});
        end
    endtask

    task automatic test_unlock;
        int cnt;
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (unlocked !== 1'b1) begin
            n_fail++; $display("FAIL unlock_latency got=%b exp=1", unlocked);
        end
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0);
            if (unlocked) cnt++; else break;
        end
        n_tests++;
        if (cnt != UNLOCK_CYC) begin
            n_fail++; $display("FAIL unlock_duration got=%0d exp=%0d", cnt, UNLOCK_CYC);
        end
        n_tests++;
        if (unlocked !== 1'b0 || lockout !== 1'b0) begin
            n_fail++; $display("FAIL unlock_relocked got=%b%b exp=00", unlocked, lockout);
        end
    endtask

    task automatic test_lockout;
        int cnt, alarms, opened;
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        for (int w = 0; w < 3; w++) begin
            for (int b = 0; b < WINDOW; b++) tick(1'b1, 1'b0, 1'b0, 1'b0);
            if (w < 2) begin
                n_tests++;
                if (fail_cnt !== 2'(w + 1) || lockout !== 1'b0) begin
                    n_fail++; $display("FAIL lockout_fail_step w=%0d got=%0d exp=%0d", w, fail_cnt, w + 1);
                end
            end
        end
        n_tests++;
        if (alarm !== 1'b1 || lockout !== 1'b1 || fail_cnt !== 2'd3) begin
            n_fail++; $display("FAIL lockout_entry got=alarm%b lockout%b fail%0d exp=alarm1 lockout1 fail3", alarm, lockout, fail_cnt);
        end
        cnt = 1; alarms = 1; opened = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1'b1, 1'b1, 1'(i % 2), 1'b0);
            if (alarm) alarms++;
            if (unlocked) opened++;
            if (lockout) cnt++; else break;
        end
        n_tests++;
        if (cnt != LOCKOUT_CYC) begin
            n_fail++; $display("FAIL lockout_duration got=%0d exp=%0d", cnt, LOCKOUT_CYC);
        end
        n_tests++;
        if (alarms != 1) begin
            n_fail++; $display("FAIL lockout_alarm_pulses got=%0d exp=1", alarms);
        end
        n_tests++;
        if (opened != 0) begin
            n_fail++; $display("FAIL lockout_match_ignored got=%0d unlocked cycles exp=0", opened);
        end
        n_tests++;
        if (fail_cnt !== 2'd0) begin
            n_fail++; $display("FAIL lockout_exit_fail_cnt got=%0d exp=0", fail_cnt);
        end
    endtask

    task automatic test_fail_clear;
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        for (int b = 0; b < 2 * WINDOW; b++) tick(1'b1, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (fail_cnt !== 2'd2) begin
            n_fail++; $display("FAIL clear_two_fails got=%0d exp=2", fail_cnt);
        end
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (fail_cnt !== 2'd0 || unlocked !== 1'b1) begin
            n_fail++; $display("FAIL clear_on_match got=fail%0d unl%b exp=fail0 unl1", fail_cnt, unlocked);
        end
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        for (int b = 0; b < WINDOW; b++) tick(1'b1, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (fail_cnt !== 2'd1 || lockout !== 1'b0) begin
            n_fail++; $display("FAIL clear_later_fail got=%0d exp=1", fail_cnt);
        end
    endtask

    task automatic test_coincident;
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        for (int b = 0; b < WINDOW - 1; b++) tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (unlocked !== 1'b1 || fail_cnt !== 2'd0 || alarm !== 1'b0) begin
            n_fail++; $display("FAIL coincident_match got=unl%b fail%0d exp=unl1 fail0", unlocked, fail_cnt);
        end
    endtask

    task automatic test_relock;
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (unlocked !== 1'b1) begin
            n_fail++; $display("FAIL relock_still_open got=%b exp=1", unlocked);
        end
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (unlocked !== 1'b0 || lockout !== 1'b0) begin
            n_fail++; $display("FAIL relock_priority got=%b exp=0", unlocked);
        end
    endtask

    task automatic test_reset_mid;
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        n_tests++;
        if ({unlocked, lockout, alarm, fail_cnt} !== 5'b0) begin
            n_fail++; $display("FAIL reset_mid_unlocked got=%b exp=00000", {unlocked, lockout, alarm, fail_cnt});
        end
        for (int b = 0; b < 3 * WINDOW; b++) tick(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (lockout !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_pre_lockout got=%b exp=1", lockout);
        end
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        n_tests++;
        if ({unlocked, lockout, alarm, fail_cnt} !== 5'b0) begin
            n_fail++; $display("FAIL reset_mid_lockout got=%b exp=00000", {unlocked, lockout, alarm, fail_cnt});
        end
    endtask

    task automatic test_random;
        logic bv, m, rl, r;
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 4000; c++) begin
            bv = ($urandom_range(3, 0) != 0);
            m  = (c < 2000) ? ($urandom_range(199, 0) == 0) : ($urandom_range(19, 0) == 0);
            rl = ($urandom_range(7, 0) == 0);
            r  = ($urandom_range(599, 0) == 0);
            tick(bv, m, rl, r);
            n_tests++;
            if (unlocked !== (m_open > 0)) begin
                n_fail++; $display("FAIL rand_unlocked cyc=%0d got=%b exp=%b", c, unlocked, (m_open > 0));
            end
            n_tests++;
            if (lockout !== (m_block > 0)) begin
                n_fail++; $display("FAIL rand_lockout cyc=%0d got=%b exp=%b", c, lockout, (m_block > 0));
            end
            n_tests++;
            if (alarm !== m_alarm) begin
                n_fail++; $display("FAIL rand_alarm cyc=%0d got=%b exp=%b", c, alarm, m_alarm);
            end
            n_tests++;
            if (fail_cnt !== 2'(m_fails)) begin
                n_fail++; $display("FAIL rand_fail_cnt cyc=%0d got=%0d exp=%0d", c, fail_cnt, m_fails);
            end
        end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset;
        test_unlock;
        test_lockout;
        test_fail_clear;
        test_coincident;
        test_relock;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
